// File: rtl/wb_skid_reg_if.sv
// MEM->WB handshake bundle for the write-back skid register.
// slave: the register itself; master: the MEM/WB stages around it.
interface wb_skid_reg_if #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_alu_result;
   logic [XLEN-1:0] in_read_data;
   logic [XLEN-1:0] in_pc_plus4;
   logic [XLEN-1:0] in_imm_ext;
   logic [1:0]      in_result_src;
   logic [RD_W-1:0] in_rd;
   logic            in_reg_write;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_a;
   logic [XLEN-1:0] out_b;
   logic [XLEN-1:0] out_c;
   logic [XLEN-1:0] out_d;
   logic [1:0]      out_s;
   logic [RD_W-1:0] out_rd;
   logic            out_reg_write;

   modport slave (
      input  flush, in_valid, in_alu_result, in_read_data, in_pc_plus4, in_imm_ext,
             in_result_src, in_rd, in_reg_write, out_ready,
      output in_ready, out_valid, out_a, out_b, out_c, out_d, out_s, out_rd, out_reg_write
   );

   modport master (
      output flush, in_valid, in_alu_result, in_read_data, in_pc_plus4, in_imm_ext,
             in_result_src, in_rd, in_reg_write, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_c, out_d, out_s, out_rd, out_reg_write
   );
endinterface

// File: rtl/wb_skid_reg.sv
// MEM/WB pipeline register with a 1-entry skid buffer; in_ready is registered.
// Optional WB_RETIRE_CNT_EN adds a retire_count output counting every transfer.
module wb_skid_reg #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   wb_skid_reg_if.slave     bus
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]      retire_count
`endif
);

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] c;
      logic [XLEN-1:0] d;
      logic [1:0]      s;
      logic [RD_W-1:0] rd;
      logic            rw;
   } entry_t;

   entry_t r_main, r_skid;
   logic   r_out_valid, r_skid_valid, r_in_ready;

   entry_t w_in, w_main_nxt, w_skid_nxt;
   logic   w_ov_nxt, w_sv_nxt;
   logic   w_accept, w_xfer;

   assign w_in.a  = bus.in_alu_result;
   assign w_in.b  = bus.in_read_data;
   assign w_in.c  = bus.in_pc_plus4;
   assign w_in.d  = bus.in_imm_ext;
   assign w_in.s  = bus.in_result_src;
   assign w_in.rd = bus.in_rd;
   assign w_in.rw = bus.in_reg_write;

   assign w_accept = bus.in_valid & r_in_ready;
   assign w_xfer   = r_out_valid & bus.out_ready;

   // Skid always drains into main first so ordering is preserved.
   always_comb begin
      w_main_nxt = r_main;
      w_skid_nxt = r_skid;
      w_ov_nxt   = r_out_valid;
      w_sv_nxt   = r_skid_valid;
      if (bus.flush) begin
         w_ov_nxt = 1'b0;
         w_sv_nxt = 1'b0;
      end else if (!r_out_valid || w_xfer) begin
         if (r_skid_valid) begin
            w_main_nxt = r_skid;
            w_ov_nxt   = 1'b1;
            if (w_accept) w_skid_nxt = w_in;
            else          w_sv_nxt   = 1'b0;
         end else if (w_accept) begin
            w_main_nxt = w_in;
            w_ov_nxt   = 1'b1;
         end else begin
            w_ov_nxt   = 1'b0;
         end
      end else if (w_accept) begin
         w_skid_nxt = w_in;
         w_sv_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else begin
         r_main       <= w_main_nxt;
         r_skid       <= w_skid_nxt;
         r_out_valid  <= w_ov_nxt;
         r_skid_valid <= w_sv_nxt;
         r_in_ready   <= !w_sv_nxt;
      end
   end

   assign bus.in_ready      = r_in_ready;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_a         = r_main.a;
   assign bus.out_b         = r_main.b;
   assign bus.out_c         = r_main.c;
   assign bus.out_d         = r_main.d;
   assign bus.out_s         = r_main.s;
   assign bus.out_rd        = r_main.rd;
   // x0 is hardwired zero, so writes to it never reach the register file.
   assign bus.out_reg_write = r_out_valid & r_main.rw & (r_main.rd != '0);

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] r_retire_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_retire_cnt <= '0;
      else if (w_xfer) r_retire_cnt <= r_retire_cnt + 32'd1;
   end

   assign retire_count = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_skid_reg.sv
// Directed self-checking bench for wb_skid_reg: reset, streaming, back-pressure,
// x0 suppression, flush and (with WB_RETIRE_CNT_EN) the retire counter.
module tb_wb_skid_reg;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   wb_skid_reg_if #(.XLEN(32), .RD_W(5)) bus ();
`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_count;
`endif

   wb_skid_reg #(.XLEN(32), .RD_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef WB_RETIRE_CNT_EN
      ,
      .retire_count (retire_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdat,
                        input logic [1:0] s, input logic [4:0] rd, input logic rw);
      bus.in_valid      = v;
      bus.in_alu_result = alu;
      bus.in_read_data  = rdat;
      bus.in_pc_plus4   = alu + 32'd4;
      bus.in_imm_ext    = ~alu;
      bus.in_result_src = s;
      bus.in_rd         = rd;
      bus.in_reg_write  = rw;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
      n_checks++; if (bus.out_reg_write !== 1'b0) begin n_fail++; $display("FAIL reset out_reg_write: got %b want 0", bus.out_reg_write); end
      n_checks++; if ({bus.out_a, bus.out_b, bus.out_c, bus.out_d} !== 128'd0) begin n_fail++; $display("FAIL reset data: got %h %h %h %h want 0", bus.out_a, bus.out_b, bus.out_c, bus.out_d); end
      n_checks++; if ({bus.out_s, bus.out_rd} !== 7'd0) begin n_fail++; $display("FAIL reset s/rd: got %h %h want 0", bus.out_s, bus.out_rd); end
   endtask

   task automatic test_streaming();
      logic [31:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      @(negedge clk);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b1, vals[i], 32'h100 + i, 2'd2, 5'd5, 1'b1);
         tick();
         n_checks++; if (bus.out_a !== vals[i] || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream[%0d] out_a: got %h v=%b want %h v=1", i, bus.out_a, bus.out_valid, vals[i]); end
         n_checks++; if (bus.out_s !== 2'd2 || bus.out_rd !== 5'd5 || bus.out_c !== vals[i] + 32'd4) begin n_fail++; $display("FAIL stream[%0d] fields: got s=%0d rd=%0d c=%h", i, bus.out_s, bus.out_rd, bus.out_c); end
         n_checks++; if (bus.out_reg_write !== 1'b1) begin n_fail++; $display("FAIL stream[%0d] out_reg_write: got %b want 1", i, bus.out_reg_write); end
      end
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream drain out_valid: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_back_pressure();
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(1'b1, 32'hA, 32'h0, 2'd0, 5'd3, 1'b1);
      tick();
      n_checks++; if (bus.out_a !== 32'hA || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp first: got a=%h rdy=%b want a=a rdy=1", bus.out_a, bus.in_ready); end
      @(negedge clk);
      drive(1'b1, 32'hB, 32'h0, 2'd0, 5'd4, 1'b1);
      tick();
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp full in_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (bus.out_a !== 32'hA || bus.out_rd !== 5'd3) begin n_fail++; $display("FAIL bp hold: got a=%h rd=%0d want a=a rd=3", bus.out_a, bus.out_rd); end
      @(negedge clk);
      drive(1'b1, 32'hC, 32'h0, 2'd0, 5'd6, 1'b1);  // not accepted: in_ready=0
      tick();
      n_checks++; if (bus.out_a !== 32'hA || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp stall: got a=%h v=%b rdy=%b", bus.out_a, bus.out_valid, bus.in_ready); end
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      n_checks++; if (bus.out_a !== 32'hB || bus.out_valid !== 1'b1 || bus.out_rd !== 5'd4) begin n_fail++; $display("FAIL bp second: got a=%h v=%b rd=%0d want a=b v=1 rd=4", bus.out_a, bus.out_valid, bus.out_rd); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp in_ready return: got %b want 1", bus.in_ready); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp drain: got v=%b a=%h want v=0 (no dup/C)", bus.out_valid, bus.out_a); end
   endtask

   task automatic test_x0();
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h7, 32'hDEADBEEF, 2'd1, 5'd0, 1'b1);
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_b !== 32'hDEADBEEF) begin n_fail++; $display("FAIL x0 entry: got v=%b b=%h want v=1 b=deadbeef", bus.out_valid, bus.out_b); end
      n_checks++; if (bus.out_reg_write !== 1'b0) begin n_fail++; $display("FAIL x0 out_reg_write: got %b want 0", bus.out_reg_write); end
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
      tick();
      n_checks++; if (bus.out_valid !== 1'b0 || bus.out_b !== 32'hDEADBEEF || bus.out_reg_write !== 1'b0) begin n_fail++; $display("FAIL x0 after: got v=%b b=%h we=%b want v=0 b=deadbeef we=0", bus.out_valid, bus.out_b, bus.out_reg_write); end
   endtask

   task automatic test_flush();
      int seen;
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h51, 32'h0, 2'd0, 5'd7, 1'b1);
      @(negedge clk);
      drive(1'b1, 32'h52, 32'h0, 2'd0, 5'd8, 1'b1);
      tick();
      n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush setup: got rdy=%b v=%b want 0/1", bus.in_ready, bus.out_valid); end
      @(negedge clk);
      bus.flush = 1'b1;
      drive(1'b1, 32'h53, 32'h0, 2'd0, 5'd9, 1'b1);
      tick();
      n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush full: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
      // Flush with in_ready=1: the entry accepted in the flush cycle is dropped.
      @(negedge clk);
      bus.flush = 1'b0;
      drive(1'b1, 32'h61, 32'h0, 2'd0, 5'd10, 1'b1);
      @(negedge clk);
      bus.flush = 1'b1;
      drive(1'b1, 32'h62, 32'h0, 2'd0, 5'd11, 1'b1);
      tick();
      n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush accept: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
      @(negedge clk);
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.out_valid !== 1'b0) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush leak: got %0d valid cycles want 0", seen); end
   endtask

`ifdef WB_RETIRE_CNT_EN
   task automatic test_retire_cnt();
      // Transfers since reset: 3 streaming, 2 back-pressure, 1 x0.
      n_checks++; if (retire_count !== 32'd6) begin n_fail++; $display("FAIL retire count: got %0d want 6", retire_count); end
      @(negedge clk);
      force dut.r_retire_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_retire_cnt;
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h77, 32'h0, 2'd0, 5'd1, 1'b1);
      tick();
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
      tick();
      n_checks++; if (retire_count !== 32'd0) begin n_fail++; $display("FAIL retire wrap: got %h want 0", retire_count); end
      @(negedge clk);
      bus.flush = 1'b1;
      tick();
      @(negedge clk);
      bus.flush = 1'b0;
      tick();
      n_checks++; if (retire_count !== 32'd0) begin n_fail++; $display("FAIL retire flush: got %h want 0", retire_count); end
   endtask
`endif

   initial begin
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0);
      test_reset();
      test_streaming();
      test_back_pressure();
      test_x0();
      test_flush();
`ifdef WB_RETIRE_CNT_EN
      test_retire_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
